// File: rtl/uart_transmitter_if.sv
// TX FIFO read port as seen by the UART transmitter.
//
// Handshake: the FIFO is show-ahead. While tx_data_fifo_empty is low, the
// head word on tx_data_fifo_data_out is valid. This plays the role of
// "valid = !empty". The transmitter accepts the word by raising
// tx_data_fifo_rd_req ("ready") for exactly one clk. The word is consumed
// and the FIFO pops on that same rising edge. rd_req is never raised while
// empty is high.
interface uart_transmitter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_data_fifo_empty;
  logic [DATA_WIDTH-1:0] tx_data_fifo_data_out;
  logic                  tx_data_fifo_rd_req;

  // Transmitter side: pops words from the FIFO.
  modport master (
    input  tx_data_fifo_empty,
    input  tx_data_fifo_data_out,
    output tx_data_fifo_rd_req
  );

  // FIFO side: offers the head word and observes pops.
  modport slave (
    output tx_data_fifo_empty,
    output tx_data_fifo_data_out,
    input  tx_data_fifo_rd_req
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: pulls one word per frame from a show-ahead TX FIFO and
// serialises it as start / data (LSB first) / optional parity / stop bits.
// Each bit lasts 16 ticks of the 16x baud enable clken.
module uart_transmitter #(
  parameter int DATA_WIDTH     = 8,
  parameter int DATA_BIT_WIDTH = 8,
  parameter int STOP_BIT_WIDTH = 1,
  parameter int PARITY_EN      = 0,
  parameter int PARITY_ODD     = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic                cts_n,
  uart_transmitter_if.master  fifo,
  output logic                tx,
  output logic                tx_busy,
  output logic                tx_done,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BIT_WIDTH - 1);
  localparam logic [2:0] LAST_STOP_BIT = 3'(STOP_BIT_WIDTH - 1);
  localparam logic       ODD_SEL       = (PARITY_ODD != 0);
  localparam logic       HAS_PARITY    = (PARITY_EN != 0);

  state_e                    state_q, state_d;
  logic [3:0]                tick_q, tick_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [DATA_BIT_WIDTH-1:0] shift_q, shift_d;
  logic                      parity_q, parity_d;
  logic                      tx_q, tx_d;
  logic                      done_q, done_d;
  logic                      rd_req;
  logic                      bit_end;
  logic [DATA_BIT_WIDTH-1:0] head_bits;

  // Only the low DATA_BIT_WIDTH bits of the FIFO word form the frame.
  assign head_bits = fifo.tx_data_fifo_data_out[DATA_BIT_WIDTH-1:0];

  // A bit time finishes on the 16th enabled tick.
  assign bit_end = clken && (tick_q == 4'd15);

  // Pop is gated by reset_n so nothing is popped while reset is held.
  assign fifo.tx_data_fifo_rd_req = rd_req & reset_n;

  assign tx          = tx_q;
  assign tx_done     = done_q;
  assign tx_busy     = (state_q != IDLE);
  assign dbg_state_o = state_q;

  // State register and datapath registers; reset parks the line high and idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tick_q    <= 4'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: frame sequencing, bit timing and the next line level.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    rd_req    = 1'b0;

    // The tick counter runs only inside a frame and wraps 15 -> 0 at bit end.
    if (state_q != IDLE && clken) begin
      tick_d = tick_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // cts_n is looked at only here, so a frame once started always completes.
        if (!fifo.tx_data_fifo_empty && !cts_n) begin
          rd_req    = 1'b1;
          shift_d   = head_bits;
          parity_d  = (^head_bits) ^ ODD_SEL;
          tick_d    = 4'd0;
          bit_cnt_d = 3'd0;
          tx_d      = 1'b0;
          state_d   = START;
        end
      end

      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA_BIT) begin
            bit_cnt_d = 3'd0;
            if (HAS_PARITY) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          bit_cnt_d = 3'd0;
          tx_d      = 1'b1;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_cnt_q == LAST_STOP_BIT) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            tick_d    = 4'd0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // A pop only happens from IDLE with a word actually available.
  rd_req_legal_a : assert property (@(posedge clk) disable iff (!reset_n)
    fifo.tx_data_fifo_rd_req |-> (state_q == IDLE && !fifo.tx_data_fifo_empty));

  // tx_done is a single-clk pulse.
  done_pulse_a : assert property (@(posedge clk) disable iff (!reset_n)
    tx_done |=> !tx_done);

  // The line is high whenever no frame is in progress.
  idle_line_high_a : assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == IDLE) |-> tx);

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: three instances cover 8N1 (flow
// control, back-to-back, mid-frame reset), 8O2 with a sparse clken, and 8E1
// fed from a 12-bit FIFO whose upper bits must be ignored.
module tb_uart_transmitter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic clken_one;
  logic clken_b;
  logic cts_a, cts_b, cts_c;
  int   div;

  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;
  logic       tx_c, busy_c, done_c;
  logic [2:0] dbg_a, dbg_b, dbg_c;

  int tests;
  int failed;

  // ---------------- FIFO models (show-ahead) ----------------
  uart_transmitter_if #(.DATA_WIDTH(8))  fifo_a ();
  uart_transmitter_if #(.DATA_WIDTH(8))  fifo_b ();
  uart_transmitter_if #(.DATA_WIDTH(12)) fifo_c ();

  logic [7:0]  mem_a [0:7];
  logic [7:0]  mem_b [0:7];
  logic [11:0] mem_c [0:7];
  int wr_a = 0, rd_a = 0;
  int wr_b = 0, rd_b = 0;
  int wr_c = 0, rd_c = 0;

  assign fifo_a.tx_data_fifo_empty    = (wr_a == rd_a);
  assign fifo_a.tx_data_fifo_data_out = mem_a[rd_a[2:0]];
  assign fifo_b.tx_data_fifo_empty    = (wr_b == rd_b);
  assign fifo_b.tx_data_fifo_data_out = mem_b[rd_b[2:0]];
  assign fifo_c.tx_data_fifo_empty    = (wr_c == rd_c);
  assign fifo_c.tx_data_fifo_data_out = mem_c[rd_c[2:0]];

  always @(posedge clk) begin
    if (fifo_a.tx_data_fifo_rd_req) rd_a <= rd_a + 1;
    if (fifo_b.tx_data_fifo_rd_req) rd_b <= rd_b + 1;
    if (fifo_c.tx_data_fifo_rd_req) rd_c <= rd_c + 1;
  end

  // ---------------- DUTs ----------------
  uart_transmitter #(.DATA_WIDTH(8), .DATA_BIT_WIDTH(8), .STOP_BIT_WIDTH(1),
                     .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .clken(clken_one), .cts_n(cts_a),
    .fifo(fifo_a), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a),
    .dbg_state_o(dbg_a));

  uart_transmitter #(.DATA_WIDTH(8), .DATA_BIT_WIDTH(8), .STOP_BIT_WIDTH(2),
                     .PARITY_EN(1), .PARITY_ODD(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .clken(clken_b), .cts_n(cts_b),
    .fifo(fifo_b), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b),
    .dbg_state_o(dbg_b));

  uart_transmitter #(.DATA_WIDTH(12), .DATA_BIT_WIDTH(8), .STOP_BIT_WIDTH(1),
                     .PARITY_EN(1), .PARITY_ODD(0)) dut_c (
    .clk(clk), .reset_n(reset_n), .clken(clken_one), .cts_n(cts_c),
    .fifo(fifo_c), .tx(tx_c), .tx_busy(busy_c), .tx_done(done_c),
    .dbg_state_o(dbg_c));

  // ---------------- driver / checker tasks ----------------
  // Advance n cycles; stop at the falling edge. clken_b is high for every 4th rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      div++;
      clken_b = (div % 4 == 0);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wall-clock guard in case the run stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [9:0]  frame_a;
    logic [11:0] frame_b;
    logic [10:0] frame_c;
    int guard;

    tests = 0; failed = 0; div = 0;
    reset_n = 1'b0; clken_one = 1'b1; clken_b = 1'b0;
    cts_a = 1'b1; cts_b = 1'b1; cts_c = 1'b1;

    // Reset values
    tick(2);
    check("rst_tx_a",   tx_a,   1);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_rdreq_a", fifo_a.tx_data_fifo_rd_req, 0);
    check("rst_state_a", dbg_a, 0);
    check("rst_tx_b",   tx_b,   1);
    check("rst_tx_c",   tx_c,   1);
    reset_n = 1'b1;
    tick(2);

    // Flow control: word waiting but cts_n high
    mem_a[0] = 8'h55; wr_a = 1;
    tick(5);
    check("cts_block_rdreq", fifo_a.tx_data_fifo_rd_req, 0);
    check("cts_block_tx",    tx_a, 1);
    check("cts_block_busy",  busy_a, 0);
    check("cts_block_pops",  rd_a, 0);
    cts_a = 1'b0;
    #1 check("cts_fall_rdreq", fifo_a.tx_data_fifo_rd_req, 1);

    // 8N1 frame of 0x55; cts_n rises mid-frame and must not disturb it
    tick(1);
    check("a55_pops", rd_a, 1);
    frame_a = 10'b1010101010;
    for (int c = 0; c < 160; c++) begin
      check("a55_tx",   tx_a,   frame_a[c/16]);
      check("a55_busy", busy_a, 1);
      check("a55_done", done_a, 0);
      check("a55_rdreq", fifo_a.tx_data_fifo_rd_req, 0);
      if (c == 40) cts_a = 1'b1;
      tick(1);
    end
    check("a55_done_end", done_a, 1);
    check("a55_busy_end", busy_a, 0);
    check("a55_tx_end",   tx_a,   1);
    tick(1);
    check("a55_done_pulse", done_a, 0);
    check("a55_pops_end",   rd_a,   1);

    // Back-to-back 0xA5 then 0x3C
    mem_a[1] = 8'hA5; mem_a[2] = 8'h3C; wr_a = 3;
    cts_a = 1'b0;
    #1 check("b2b_rdreq1", fifo_a.tx_data_fifo_rd_req, 1);
    tick(1);
    check("b2b_pops1", rd_a, 2);
    frame_a = 10'b1101001010;
    for (int c = 0; c < 160; c++) begin
      check("b2b_tx1",   tx_a,   frame_a[c/16]);
      check("b2b_done1", done_a, 0);
      tick(1);
    end
    check("b2b_done1_end", done_a, 1);
    check("b2b_rdreq2",    fifo_a.tx_data_fifo_rd_req, 1);
    check("b2b_idle_gap",  busy_a, 0);
    tick(1);
    check("b2b_start2_tx",   tx_a,   0);
    check("b2b_start2_busy", busy_a, 1);
    check("b2b_start2_done", done_a, 0);
    check("b2b_pops2",       rd_a,   3);
    frame_a = 10'b1001111000;
    for (int c = 0; c < 160; c++) begin
      check("b2b_tx2",   tx_a, frame_a[c/16]);
      check("b2b_rdreq_mid", fifo_a.tx_data_fifo_rd_req, 0);
      tick(1);
    end
    check("b2b_done2_end", done_a, 1);
    check("b2b_rdreq_empty", fifo_a.tx_data_fifo_rd_req, 0);
    tick(5);
    check("b2b_quiet_rdreq", fifo_a.tx_data_fifo_rd_req, 0);
    check("b2b_quiet_busy",  busy_a, 0);
    check("b2b_quiet_tx",    tx_a, 1);
    check("b2b_quiet_pops",  rd_a, 3);

    // Reset at tick 5 of data bit 3 (0xF0: that bit is 0)
    mem_a[3] = 8'hF0; wr_a = 4;
    tick(1);
    tick(69);
    check("rstmid_tx_before",    tx_a, 0);
    check("rstmid_busy_before",  busy_a, 1);
    check("rstmid_state_before", dbg_a, 2);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_tx",    tx_a, 1);
    check("rstmid_busy",  busy_a, 0);
    check("rstmid_done",  done_a, 0);
    check("rstmid_rdreq", fifo_a.tx_data_fifo_rd_req, 0);
    check("rstmid_state", dbg_a, 0);
    tick(1);
    reset_n = 1'b1;
    tick(3);
    check("rstmid_pops_after", rd_a, 4);
    check("rstmid_tx_after",   tx_a, 1);
    check("rstmid_busy_after", busy_a, 0);
    mem_a[4] = 8'h81; wr_a = 5;
    tick(1);
    check("post_rst_pops", rd_a, 5);
    frame_a = 10'b1100000010;
    for (int c = 0; c < 160; c++) begin
      check("post_rst_tx", tx_a, frame_a[c/16]);
      tick(1);
    end
    check("post_rst_done", done_a, 1);

    // Even parity, 12-bit FIFO word 0xF03 -> data 0x03, parity 0, 176 ticks
    mem_c[0] = 12'hF03; wr_c = 1;
    cts_c = 1'b0;
    #1 check("c_rdreq", fifo_c.tx_data_fifo_rd_req, 1);
    tick(1);
    check("c_pops", rd_c, 1);
    frame_c = 11'b10000000110;
    for (int c = 0; c < 176; c++) begin
      check("c_tx",   tx_c,   frame_c[c/16]);
      check("c_done", done_c, 0);
      check("c_busy", busy_c, 1);
      tick(1);
    end
    check("c_done_end", done_c, 1);
    check("c_busy_end", busy_c, 0);

    // Odd parity, 2 stop bits, clken 1-in-4: 0x03 -> parity 1, 64 clk per bit
    mem_b[0] = 8'h03; wr_b = 1;
    guard = 0;
    while (!clken_b && guard < 8) begin
      tick(1);
      guard++;
    end
    cts_b = 1'b0;
    tick(1);
    check("b_pops", rd_b, 1);
    frame_b = 12'b111000000110;
    for (int c = 0; c < 768; c++) begin
      check("b_tx",   tx_b,   frame_b[c/64]);
      check("b_done", done_b, 0);
      check("b_busy", busy_b, 1);
      tick(1);
    end
    check("b_done_end", done_b, 1);
    check("b_busy_end", busy_b, 0);
    check("b_tx_end",   tx_b,   1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
